// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES-128 encryption round engine
//
// Purpose:
//   Encrypts one 128-bit block per request.
//   - The start edge performs the initial AddRoundKey.
//   - Each following clock performs one full round.
//   - The final round skips MixColumns.
//   Round keys come pre-expanded from the key-expansion stage.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       encrypt request, sampled only while idle
//   plain_in    plaintext block, byte0 in [127:120], column-major
//   key_in      cipher key (round-0 key)
//   round_keys  Nr round keys; slice k holds the key for round k+1
//   busy        high while a block is in flight
//   done        one-cycle pulse when cipher_out is updated
//   cipher_out  ciphertext, held until the next block completes

module aes_sbox #(
  parameter int N_WORDS = 4
) (
  input  logic [32*N_WORDS-1:0] din,
  output logic [32*N_WORDS-1:0] dout
);
  // Forward S-box. Entry x sits at bits [2047-8x -: 8], so entry 0x00 is the
  // leftmost byte of the table.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // {~x, 3'b111} is the bit index 2047 - 8*x.
  for (genvar i = 0; i < 4*N_WORDS; i++) begin : g_byte
    assign dout[8*i +: 8] = SBOX[{~din[8*i +: 8], 3'b111} -: 8];
  end
endmodule

module aes_round_engine #(
  parameter int Nk = 4,
  parameter int Nr = 10,
  parameter int Nb = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [32*Nb-1:0]    plain_in,
  input  logic [32*Nk-1:0]    key_in,
  input  logic [Nr*128-1:0]   round_keys,
  output logic                busy,
  output logic                done,
  output logic [32*Nb-1:0]    cipher_out
);
  localparam int BW = 32*Nb;
  localparam logic [3:0] NR_CNT = 4'(Nr);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [BW-1:0] state_q, state_d;
  logic [3:0]    round_cnt_q, round_cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [BW-1:0] cipher_q, cipher_d;

  logic [BW-1:0] sb_state;
  logic [BW-1:0] sr_state;
  logic [BW-1:0] mc_state;
  logic [127:0]  rk_slice [Nr];
  logic [127:0]  rk_cur;
  logic [3:0]    rk_idx;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r of column c takes the byte from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] res;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] res;
    logic [7:0]   a0, a1, a2, a3;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      res[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      res[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      res[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      res[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return res;
  endfunction

  aes_sbox #(.N_WORDS(Nb)) u_sbox (
    .din  (state_q),
    .dout (sb_state)
  );

  for (genvar k = 0; k < Nr; k++) begin : g_rk
    assign rk_slice[k] = round_keys[k*128 +: 128];
  end

  // round_cnt reaches Nr in FINAL, so the same index also selects the
  // final-round key (slice Nr-1).
  assign rk_idx = round_cnt_q - 4'd1;

  always_comb begin
    rk_cur = '0;
    if (rk_idx < NR_CNT) begin
      rk_cur = rk_slice[rk_idx];
    end
  end

  assign sr_state = shift_rows(sb_state);
  assign mc_state = mix_columns(sr_state);

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cipher_d    = cipher_q;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          state_d     = plain_in ^ key_in;
          round_cnt_d = 4'd1;
          busy_d      = 1'b1;
          fsm_d       = ROUND;
        end
      end
      ROUND: begin
        state_d     = mc_state ^ rk_cur;
        round_cnt_d = round_cnt_q + 4'd1;
        if (round_cnt_d == NR_CNT) begin
          fsm_d = FINAL;
        end
      end
      FINAL: begin
        cipher_d = sr_state ^ rk_cur;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        fsm_d    = IDLE;
      end
      default: begin
        fsm_d  = IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      round_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cipher_q    <= '0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cipher_q    <= cipher_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign cipher_out = cipher_q;
endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - testbench for aes_round_engine
module tb_aes_round_engine;
  localparam int NR = 10;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [127:0]      plain_in;
  logic [127:0]      key_in;
  logic [NR*128-1:0] round_keys;
  logic              busy;
  logic              done;
  logic [127:0]      cipher_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sbox_t [256];

  always #5 clk = ~clk;

  aes_round_engine #(.Nk(4), .Nr(NR), .Nb(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .plain_in   (plain_in),
    .key_in     (key_in),
    .round_keys (round_keys),
    .busy       (busy),
    .done       (done),
    .cipher_out (cipher_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      b = inv;
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                    ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [NR*128-1:0] expand_key(input logic [127:0] key);
    logic [31:0]       w [44];
    logic [31:0]       t;
    logic [7:0]        rcon;
    logic [NR*128-1:0] rk;
    rcon = 8'h01;
    rk   = '0;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 1; k <= NR; k++) begin
      rk[(k-1)*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    end
    return rk;
  endfunction

  // Presents key/plaintext and holds the key two cycles before any start.
  task automatic load(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    key_in     = k;
    plain_in   = p;
    round_keys = expand_key(k);
    repeat (2) @(negedge clk);
  endtask

  // Pulses start for one edge and waits (bounded) for done.
  task automatic run_block(output int cyc, output int busy_cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_cyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) busy_cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; plain_in = '0; key_in = '0; round_keys = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++;
    if (cipher_out !== 128'h0) begin n_fail++; $display("FAIL reset_cipher: got %h want 0", cipher_out); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_busy: got %b want 0", busy); end
  endtask

  task automatic test_fips_b();
    int cyc, bc;
    load(KEY_B, PT_B);
    run_block(cyc, bc);
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL fips_b_latency: got %0d want 10", cyc); end
    n_checks++;
    if (cipher_out !== CT_B) begin n_fail++; $display("FAIL fips_b_cipher: got %h want %h", cipher_out, CT_B); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fips_b_busy_at_done: got %b want 0", busy); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL fips_b_done_pulse: got %b want 0", done); end
    n_checks++;
    if (cipher_out !== CT_B) begin n_fail++; $display("FAIL fips_b_hold: got %h want %h", cipher_out, CT_B); end
  endtask

  task automatic test_fips_c();
    int cyc, bc;
    load(KEY_C, PT_C);
    run_block(cyc, bc);
    n_checks++;
    if (bc !== 10) begin n_fail++; $display("FAIL fips_c_busy_cycles: got %0d want 10", bc); end
    n_checks++;
    if (cipher_out !== CT_C) begin n_fail++; $display("FAIL fips_c_cipher: got %h want %h", cipher_out, CT_C); end
  endtask

  task automatic test_back_to_back();
    int first, prev, pulses, gap_bad, ct_bad;
    first = -1; prev = -1; pulses = 0; gap_bad = 0; ct_bad = 0;
    load(KEY_B, PT_B);
    start = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        if (prev >= 0 && (i - prev) != 11) gap_bad++;
        prev = i;
        if (cipher_out !== CT_B) ct_bad++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (first !== 11) begin n_fail++; $display("FAIL b2b_first_done: got %0d want 11", first); end
    n_checks++;
    if (pulses !== 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 3", pulses); end
    n_checks++;
    if (gap_bad !== 0) begin n_fail++; $display("FAIL b2b_spacing: got %0d bad gaps want 0", gap_bad); end
    n_checks++;
    if (ct_bad !== 0) begin n_fail++; $display("FAIL b2b_cipher: got %0d wrong want 0", ct_bad); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int cyc, bc, seen;
    load(KEY_B, PT_B);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b want 0", done); end
    n_checks++;
    if (cipher_out !== 128'h0) begin n_fail++; $display("FAIL midreset_cipher: got %h want 0", cipher_out); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done: got %0d pulses want 0", seen); end
    load(KEY_C, PT_C);
    run_block(cyc, bc);
    n_checks++;
    if (cipher_out !== CT_C) begin n_fail++; $display("FAIL midreset_next_cipher: got %h want %h", cipher_out, CT_C); end
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL midreset_next_latency: got %0d want 10", cyc); end
  endtask

  task automatic test_plain_change();
    int cyc, seen, changed;
    load(KEY_C, PT_C);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 30) begin
      plain_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      start = (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_checks++;
    if (cyc !== 10) begin n_fail++; $display("FAIL pchange_latency: got %0d want 10", cyc); end
    n_checks++;
    if (cipher_out !== CT_C) begin n_fail++; $display("FAIL pchange_cipher: got %h want %h", cipher_out, CT_C); end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL busy_start_ignored: got %0d pulses want 0", seen); end
    load(KEY_B, PT_B);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    changed = 0;
    while (done !== 1'b1 && cyc < 30) begin
      if (cipher_out !== CT_C) changed++;
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (changed !== 0) begin n_fail++; $display("FAIL cipher_hold: got %0d early changes want 0", changed); end
    n_checks++;
    if (cipher_out !== CT_B) begin n_fail++; $display("FAIL cipher_update: got %h want %h", cipher_out, CT_B); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c();
    test_back_to_back();
    test_reset_mid();
    test_plain_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
